// File: rtl/svnet_tree_add_sched_pkg.sv
// -----------------------------------------------------------------------------
// svnet_tree_add_sched_pkg
// Shared types and helpers for the tree-adder scheduler.
//   sched_state_e : scheduler FSM states (IDLE, BURST)
//   tag_t         : per-beat tag that travels alongside the shared adder pipe
//   sched_dbg_t   : debug view of the scheduler FSM
//   tree_lat()    : adder latency as a function of COUNT
//   sum_width()   : adder output width
//   id_width()    : requester index width
// -----------------------------------------------------------------------------
package svnet_tree_add_sched_pkg;

  // Tag and debug structs carry requester ids at a fixed width so they can
  // live in the package; blocks narrow them to their own ID_WIDTH.
  // Supports up to 256 requesters.
  localparam int MAX_ID_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                    valid;
    logic [MAX_ID_WIDTH-1:0] id;
    logic                    first;
    logic                    last;
  } tag_t;

  typedef struct packed {
    sched_state_e            state;
    logic [MAX_ID_WIDTH-1:0] lock_id;
    logic [MAX_ID_WIDTH-1:0] rr_ptr;
  } sched_dbg_t;

  // Two register levels per tree level; a single-element tree is a wire.
  function automatic int tree_lat(input int count);
    if (count <= 1) return 0;
    return 2 * $clog2(count);
  endfunction

  function automatic int sum_width(input int count, input int width);
    return $clog2(count) + width;
  endfunction

  function automatic int id_width(input int nreq);
    if (nreq < 2) return 1;
    return $clog2(nreq);
  endfunction

endpackage

// File: rtl/svnet_rr_arbiter.sv
// -----------------------------------------------------------------------------
// svnet_rr_arbiter
// Combinational rotating-priority arbiter. The first asserted request found
// scanning ptr, ptr+1, ... (mod N) wins.
//   req        in  N   request vector
//   ptr        in  IW  highest-priority index (must be < N)
//   gnt_valid  out 1   at least one request asserted
//   gnt_id     out IW  index of the winner (0 when none)
//   gnt_onehot out N   one-hot winner (all zero when none)
// -----------------------------------------------------------------------------
module svnet_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic [N-1:0]  gnt_onehot
);

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_id     = '0;
    gnt_onehot = '0;
    // Scan from lowest priority to highest so the highest-priority hit is
    // the one left standing.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_id    = IW'((int'(ptr) + k) % N);
      end
    end
    if (gnt_valid) gnt_onehot[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/svnet_tree_add_sched.sv
// -----------------------------------------------------------------------------
// svnet_tree_add_sched
// Shares one external svnet_tree_add between NREQ burst requesters and
// accumulates the per-beat tree sums into one signed result per burst.
//
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[NREQ]   beat valid per requester
//   req_last[NREQ]    final beat of the burst
//   req_data          [NREQ][COUNT][WIDTH] beat vectors
//   req_ready[NREQ]   beat accepted on valid & ready
//   add_i_data_valid  to adder i_data_valid
//   add_i_data        to adder i_data ([COUNT][WIDTH])
//   add_o_data        from adder o_data (SUM_WIDTH)
//   res_valid         single-cycle result pulse
//   res_id            owner of the result
//   res_data          signed burst sum (ACC_WIDTH, wraps)
//   dbg               FSM state, locked requester, round-robin pointer
//
// Handshake: a beat moves when req_valid[i] & req_ready[i] is high at a
// rising clk edge. req_ready is combinational from the FSM state and
// req_valid and never depends on the adder (which has no backpressure).
// A requester may drop valid without a handshake; while valid & !ready it
// must hold its data and last.
//
// Timing: the accepted beat is registered onto add_i_data in the accept
// cycle; the adder returns its sum LAT+1 clocks later (input register plus
// LAT pipeline levels). A tag pipe of LAT+1 stages behind the input stage
// reaches its end in that same cycle, and the result is registered one
// clock later: accept edge to res_valid is LAT+2 clocks.
// -----------------------------------------------------------------------------
module svnet_tree_add_sched
  import svnet_tree_add_sched_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int COUNT     = 4,
  parameter  int NREQ      = 4,
  parameter  int ACC_WIDTH = 24,
  localparam int SUM_WIDTH = sum_width(COUNT, WIDTH),
  localparam int LAT       = tree_lat(COUNT),
  localparam int ID_WIDTH  = id_width(NREQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  input  logic [NREQ-1:0]                       req_last,
  input  logic [NREQ-1:0][COUNT-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]                       req_ready,
  output logic                                  add_i_data_valid,
  output logic [COUNT-1:0][WIDTH-1:0]           add_i_data,
  input  logic [SUM_WIDTH-1:0]                  add_o_data,
  output logic                                  res_valid,
  output logic [ID_WIDTH-1:0]                   res_id,
  output logic signed [ACC_WIDTH-1:0]           res_data,
  output sched_dbg_t                            dbg
);

  // ---------------------------------------------------------------------------
  // Arbitration and FSM
  // ---------------------------------------------------------------------------
  sched_state_e        state, state_nxt;
  logic [ID_WIDTH-1:0] lock_id, lock_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_nxt;

  logic                gnt_valid;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [NREQ-1:0]     gnt_onehot;

  logic [ID_WIDTH-1:0] sel_id;
  logic                accept;
  logic                sel_last;

  svnet_rr_arbiter #(
    .N  (NREQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .gnt_onehot (gnt_onehot)
  );

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    if (int'(id) >= NREQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // In BURST only the locked requester is offered ready, so beats of one
  // burst stay contiguous in the adder pipe and one accumulator suffices.
  // Ready is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    sel_id    = gnt_id;
    if (state == ST_BURST) begin
      sel_id             = lock_id;
      req_ready[lock_id] = 1'b1;
    end else begin
      req_ready = gnt_onehot;
    end
    if (rst) req_ready = '0;
  end

  assign accept   = !rst && ((state == ST_IDLE) ? gnt_valid : req_valid[lock_id]);
  assign sel_last = req_last[sel_id];

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_id;
    rr_nxt    = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_nxt = next_id(gnt_id);
          end else begin
            state_nxt = ST_BURST;
            lock_nxt  = gnt_id;
          end
        end
      end
      ST_BURST: begin
        if (accept && sel_last) begin
          state_nxt = ST_IDLE;
          rr_nxt    = next_id(lock_id);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  always_comb begin
    dbg         = '0;
    dbg.state   = state;
    dbg.lock_id = MAX_ID_WIDTH'(lock_id);
    dbg.rr_ptr  = MAX_ID_WIDTH'(rr_ptr);
  end

  // ---------------------------------------------------------------------------
  // Input stage: beat to the adder, tag captured alongside it
  // ---------------------------------------------------------------------------
  tag_t in_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_i_data_valid <= 1'b0;
      add_i_data       <= '0;
      in_tag           <= '0;
    end else begin
      add_i_data_valid <= accept;
      if (accept) add_i_data <= req_data[sel_id];
      in_tag.valid <= accept;
      in_tag.id    <= MAX_ID_WIDTH'(sel_id);
      // Any beat accepted from IDLE opens a burst.
      in_tag.first <= (state == ST_IDLE);
      in_tag.last  <= sel_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe: LAT+1 stages, the last one lines up with add_o_data
  // ---------------------------------------------------------------------------
  tag_t [LAT:0] tag_pipe;
  tag_t         tag_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= in_tag;
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_exit = tag_pipe[LAT];

  // ---------------------------------------------------------------------------
  // Accumulator and result
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_x;
  logic signed [ACC_WIDTH-1:0] acc_next;

  assign sum_x    = ACC_WIDTH'($signed(add_o_data));
  // A first beat restarts the sum, so back-to-back bursts need no idle gap.
  assign acc_next = tag_exit.first ? sum_x : acc + sum_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= tag_exit.valid && tag_exit.last;
      if (tag_exit.valid) begin
        acc <= acc_next;
        if (tag_exit.last) begin
          res_data <= acc_next;
          res_id   <= ID_WIDTH'(tag_exit.id);
        end
      end
    end
  end

endmodule

// File: tb/tb_svnet_tree_add_sched.sv
// -----------------------------------------------------------------------------
// tb_svnet_tree_add_sched
// Directed bench for svnet_tree_add_sched. A second instance with a 10-bit
// accumulator shares the request inputs and is used for the wrap case.
// The shared adder is modelled here as LAT+1 register stages.
// -----------------------------------------------------------------------------
module tb_svnet_tree_add_sched;
  import svnet_tree_add_sched_pkg::*;

  localparam int WIDTH  = 8;
  localparam int COUNT  = 4;
  localparam int NREQ   = 4;
  localparam int ACC_W  = 24;
  localparam int ACC_WW = 10;
  localparam int SUM_W  = $clog2(COUNT) + WIDTH;
  localparam int LAT    = 2 * $clog2(COUNT);
  localparam int ID_W   = $clog2(NREQ);
  localparam int DW     = COUNT * WIDTH;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs and adder models
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0]                       req_last;
  logic [NREQ-1:0][COUNT-1:0][WIDTH-1:0] req_data;

  logic [NREQ-1:0]             req_ready;
  logic                        add_i_data_valid;
  logic [COUNT-1:0][WIDTH-1:0] add_i_data;
  logic [SUM_W-1:0]            add_o_data;
  logic                        res_valid;
  logic [ID_W-1:0]             res_id;
  logic [ACC_W-1:0]            res_data;
  sched_dbg_t                  dbg;

  logic [NREQ-1:0]             req_ready_w;
  logic                        add_i_data_valid_w;
  logic [COUNT-1:0][WIDTH-1:0] add_i_data_w;
  logic [SUM_W-1:0]            add_o_data_w;
  logic                        res_valid_w;
  logic [ID_W-1:0]             res_id_w;
  logic [ACC_WW-1:0]           res_data_w;
  sched_dbg_t                  dbg_w;

  svnet_tree_add_sched #(
    .WIDTH(WIDTH), .COUNT(COUNT), .NREQ(NREQ), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .add_i_data_valid(add_i_data_valid), .add_i_data(add_i_data),
    .add_o_data(add_o_data),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .dbg(dbg)
  );

  svnet_tree_add_sched #(
    .WIDTH(WIDTH), .COUNT(COUNT), .NREQ(NREQ), .ACC_WIDTH(ACC_WW)
  ) dut_w (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready_w),
    .add_i_data_valid(add_i_data_valid_w), .add_i_data(add_i_data_w),
    .add_o_data(add_o_data_w),
    .res_valid(res_valid_w), .res_id(res_id_w), .res_data(res_data_w),
    .dbg(dbg_w)
  );

  function automatic logic [SUM_W-1:0] tree_sum(input logic [COUNT-1:0][WIDTH-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < COUNT; i++) s += int'($signed(v[i]));
    return SUM_W'(s);
  endfunction

  logic [SUM_W-1:0] add_pipe   [0:LAT];
  logic [SUM_W-1:0] add_pipe_w [0:LAT];

  always @(posedge clk) begin
    add_pipe[0]   <= tree_sum(add_i_data);
    add_pipe_w[0] <= tree_sum(add_i_data_w);
    for (int k = 1; k <= LAT; k++) begin
      add_pipe[k]   <= add_pipe[k-1];
      add_pipe_w[k] <= add_pipe_w[k-1];
    end
  end

  assign add_o_data   = add_pipe[LAT];
  assign add_o_data_w = add_pipe_w[LAT];

  // ---------------------------------------------------------------------------
  // Scoreboard: expected queue, observed results
  // ---------------------------------------------------------------------------
  logic [ID_W+ACC_W-1:0]  exp_q[$];
  logic [ID_W+ACC_W-1:0]  got_q[$];
  int                     got_cyc_q[$];
  int                     cyc_seen[$];
  logic [ID_W+ACC_WW-1:0] w_got_q[$];
  int                     acc_cyc;
  int                     tests = 0;
  int                     fails = 0;

  always @(negedge clk) begin
    if (res_valid) begin
      got_q.push_back({res_id, res_data});
      got_cyc_q.push_back(cyc);
    end
    if (res_valid_w) w_got_q.push_back({res_id_w, res_data_w});
    // The handshake seen here completes at the next edge, where cyc steps.
    if (|(req_valid & req_ready)) acc_cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int id, input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    req_valid[id] = 1'b1;
    req_last[id]  = last;
    req_data[id]  = d;
    @(negedge clk);
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("handshake_req%0d", id), 32'(req_ready[id]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic push_exp(input int id, input int sum);
    exp_q.push_back({ID_W'(id), ACC_W'(sum)});
  endtask

  task automatic wait_results(input string name, input int max_cyc);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_result"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    cyc_seen = got_cyc_q;
    got_cyc_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: single-beat bursts
  // ---------------------------------------------------------------------------
  typedef struct {
    int             id;
    logic [DW-1:0]  d;
    int             sum;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    rst       = 1'b1;

    vecs[0] = '{0, pk(1, 2, 3, 4), 10};
    vecs[1] = '{1, pk(-1, -1, -1, -1), -4};
    vecs[2] = '{2, pk(127, 127, 127, 127), 508};
    vecs[3] = '{3, pk(-128, -128, -128, -128), -512};
    vecs[4] = '{0, pk(5, -5, 7, -7), 0};
    vecs[5] = '{1, pk(100, -20, 3, 0), 83};

    // Reset state
    idle(3);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_add_valid", 32'(add_i_data_valid), 32'd0);
    check("rst_add_data", 32'(add_i_data), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("rst_rr_ptr", 32'(dbg.rr_ptr), 32'd0);
    rst = 1'b0;
    idle(2);
    check("idle_ready", 32'(req_ready), 32'd0);

    // Table-driven single beats, with latency check on each
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].id, vecs[i].sum);
      send_beat(vecs[i].id, vecs[i].d, 1'b1);
      wait_results($sformatf("vec%0d", i), 20);
      check($sformatf("vec%0d_latency", i),
            32'((cyc_seen.size() > 0) ? (cyc_seen[0] - acc_cyc) : -1), 32'(LAT + 2));
    end

    // Burst with idle gaps: -4 + 508 + 5
    push_exp(1, 509);
    send_beat(1, pk(-1, -1, -1, -1), 1'b0);
    check("burst_state", 32'(dbg.state), 32'(ST_BURST));
    idle(2);
    send_beat(1, pk(127, 127, 127, 127), 1'b0);
    idle(3);
    send_beat(1, pk(0, 0, 0, 5), 1'b1);
    wait_results("burst", 20);
    check("burst_rr_ptr", 32'(dbg.rr_ptr), 32'd2);

    // Move the pointer back to 0 with a req3 single beat
    push_exp(3, 1);
    send_beat(3, pk(0, 0, 0, 1), 1'b1);
    wait_results("ptr_wrap", 20);
    check("ptr_wrap_rr_ptr", 32'(dbg.rr_ptr), 32'd0);

    // Contention: all four single-beat bursts at once
    for (int g = 0; g < NREQ; g++) begin
      req_data[g] = pk(g + 1, g + 1, g + 1, g + 1);
      push_exp(g, 4 * (g + 1));
    end
    req_valid = '1;
    req_last  = '1;
    for (int g = 0; g < NREQ; g++) begin
      @(negedge clk);
      check($sformatf("cont_ready%0d", g), 32'(req_ready), 32'd1 << g);
      @(posedge clk);
      #1;
      req_valid[g] = 1'b0;
      req_last[g]  = 1'b0;
    end
    wait_results("contention", 20);
    check("cont_consecutive",
          32'((cyc_seen.size() == 4) ? (cyc_seen[3] - cyc_seen[0]) : -1), 32'd3);
    check("cont_rr_ptr", 32'(dbg.rr_ptr), 32'd0);

    // Lock: req0 waits for req2's 4-beat burst to finish
    push_exp(2, 4 + 8 + 12 + 100);
    push_exp(0, -8);
    send_beat(2, pk(1, 1, 1, 1), 1'b0);
    send_beat(2, pk(2, 2, 2, 2), 1'b0);
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b1;
    req_data[0]  = pk(-2, -2, -2, -2);
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b0;
    req_data[2]  = pk(3, 3, 3, 3);
    @(negedge clk);
    check("lock_ready_beat3", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_data[2] = pk(10, 20, 30, 40);
    req_last[2] = 1'b1;
    @(negedge clk);
    check("lock_ready_beat4", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    @(negedge clk);
    check("lock_release_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    wait_results("lock", 20);

    // Wrap: 3 x 508 = 1524; the 10-bit instance must give 500
    w_got_q.delete();
    push_exp(1, 1524);
    send_beat(1, pk(127, 127, 127, 127), 1'b0);
    send_beat(1, pk(127, 127, 127, 127), 1'b0);
    send_beat(1, pk(127, 127, 127, 127), 1'b1);
    wait_results("wrap_wide", 20);
    check("wrap_count", 32'(w_got_q.size()), 32'd1);
    check("wrap_result", (w_got_q.size() > 0) ? 32'(w_got_q[0]) : 32'hFFFF_FFFF,
          32'({2'd1, 10'd500}));

    // Reset two cycles after req3 accepts a non-last beat
    send_beat(3, pk(9, 9, 9, 9), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    req_valid[3] = 1'b1;
    req_last[3]  = 1'b0;
    req_data[3]  = pk(50, 50, 50, 50);
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("midrst_rr_ptr", 32'(dbg.rr_ptr), 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    req_valid[3] = 1'b0;
    idle(10);
    wait_results("midrst_flush", 1);
    push_exp(3, 20);
    send_beat(3, pk(1, 2, 3, 4), 1'b0);
    send_beat(3, pk(4, 3, 2, 1), 1'b1);
    wait_results("post_rst", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
